uart_tx_param: RTL and testbench



---
 rtl/uart_tx_param.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with integrated FIFO; optional parity via UART_TX_PARITY_EN
module uart_tx_param #(
    parameter int CLK_HZ     = 20000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          i_clk_20mhz,
    input  logic                          i_rst_20mhz,
    output logic                          eo_uart_tx,
    input  logic [7:0]                    i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = PTR_W + 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP  = 3'(STOP_BITS - 1);
    localparam logic [FCW-1:0]   FULL_COUNT = FCW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [FCW-1:0]       r_count;

    // Serialiser state
    state_t               r_state;
    logic [CNT_W-1:0]     r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_line;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_nempty;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_unused_cfg;

    assign w_fifo_nempty = (r_count != '0);
    assign o_tx_ready    = (r_count != FULL_COUNT);
    assign w_push        = i_tx_valid && o_tx_ready;
    assign w_bit_end     = (r_baud_cnt == DIV_LAST);
    assign w_stop_end    = (r_state == S_STOP) && w_bit_end && (r_bit_idx == LAST_STOP);
    // Pop either to leave IDLE or to chain the next frame straight out of STOP
    assign w_pop         = w_fifo_nempty && ((r_state == S_IDLE) || w_stop_end);
    assign w_head        = r_mem[r_rd_ptr];

    assign eo_uart_tx    = r_line;
    assign o_fifo_count  = r_count;
    assign o_tx_busy     = (r_state != S_IDLE) || w_fifo_nempty;

    // Upper data bits and, without parity, PARITY_ODD have no effect
    assign w_unused_cfg  = (^i_tx_data) ^ (PARITY_ODD != 0);

    // FIFO data array: written on every accepted push, never reset
    always_ff @(posedge i_clk_20mhz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tx_data[DATA_BITS-1:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM: the line register is loaded together with each state change
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_line     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                r_parity <= (^w_head) ^ (PARITY_ODD != 0);
`endif
            end

            if (r_state == S_IDLE) begin
                r_baud_cnt <= '0;
            end else if (w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_line <= 1'b1;
                    if (w_pop) begin
                        r_state <= S_START;
                        r_line  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_line    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_line  <= r_parity;
`else
                            r_state   <= S_STOP;
                            r_bit_idx <= '0;
                            r_line    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_line    <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state   <= S_STOP;
                        r_bit_idx <= '0;
                        r_line    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_STOP) begin
                            if (w_pop) begin
                                r_state <= S_START;
                                r_line  <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_line  <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_line  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed self-checking bench for uart_tx_param
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam int P_EN = 1;
`else
    localparam int P_EN = 0;
`endif
    localparam int FRAME_A = (1 + 8 + P_EN + 1) * 10;
    localparam int FRAME_B = (1 + 5 + P_EN + 2) * 10;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_line, a_ready, a_busy;
    logic       b_line, b_ready, b_busy;
    logic [4:0] a_count;
    logic [2:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic       cap_line [0:1999];
    logic [4:0] cap_cnt  [0:1999];
    logic       cap_busy [0:1999];

    uart_tx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .STOP_BITS(1),
                    .FIFO_DEPTH(16), .PARITY_ODD(0)) u_a (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst), .eo_uart_tx(a_line),
        .i_tx_data(a_data), .i_tx_valid(a_valid), .o_tx_ready(a_ready),
        .o_tx_busy(a_busy), .o_fifo_count(a_count));

    uart_tx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(5), .STOP_BITS(2),
                    .FIFO_DEPTH(4), .PARITY_ODD(0)) u_b (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst), .eo_uart_tx(b_line),
        .i_tx_data(b_data), .i_tx_valid(b_valid), .o_tx_ready(b_ready),
        .o_tx_busy(b_busy), .o_fifo_count(b_count));

`ifdef UART_TX_PARITY_EN
    logic [7:0] c_data;
    logic       c_valid, c_line, c_ready, c_busy;
    logic [4:0] c_count;
    uart_tx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .STOP_BITS(1),
                    .FIFO_DEPTH(16), .PARITY_ODD(1)) u_c (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst), .eo_uart_tx(c_line),
        .i_tx_data(c_data), .i_tx_valid(c_valid), .o_tx_ready(c_ready),
        .o_tx_busy(c_busy), .o_fifo_count(c_count));
`endif

    // Expected line level k clocks after the start bit begins (DIV = 10)
    function automatic logic exp_level(input logic [7:0] b, input int nbits, input int podd, input int k);
        int   bi;
        logic p;
        bi = k / 10;
        p  = podd[0];
        for (int j = 0; j < nbits; j++) p = p ^ b[j];
        if (bi == 0) return 1'b0;
        if (bi <= nbits) return b[bi-1];
        if ((P_EN == 1) && (bi == nbits + 1)) return p;
        return 1'b1;
    endfunction

    task automatic capture(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 0) begin
                cap_line[i] = a_line; cap_cnt[i] = a_count; cap_busy[i] = a_busy;
            end else if (sel == 1) begin
                cap_line[i] = b_line; cap_cnt[i] = 5'(b_count); cap_busy[i] = b_busy;
            end else begin
`ifdef UART_TX_PARITY_EN
                cap_line[i] = c_line; cap_cnt[i] = c_count; cap_busy[i] = c_busy;
`endif
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
`ifdef UART_TX_PARITY_EN
        c_valid = 1'b0; c_data = 8'h00;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (a_line !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b want 1", a_line); end
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_ready); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_count); end
        n_checks++; if (b_line !== 1'b1) begin n_fail++; $display("FAIL reset_b_line: got %b want 1", b_line); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int bad;
        bad = 0;
        a_data = 8'h55; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (a_line !== 1'b1) begin n_fail++; $display("FAIL latency_line_before_fall: got %b want 1", a_line); end
        n_checks++; if (a_count !== 5'd1) begin n_fail++; $display("FAIL latency_count: got %0d want 1", a_count); end
        capture(0, FRAME_A + 1);
        n_checks++; if (cap_line[0] !== 1'b0) begin n_fail++; $display("FAIL start_bit_fall: got %b want 0", cap_line[0]); end
        for (int k = 0; k < FRAME_A; k++) if (cap_line[k] !== exp_level(8'h55, 8, 0, k)) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL frame_55: %0d wrong bit-times, want 0", bad); end
        n_checks++; if (cap_busy[FRAME_A-1] !== 1'b1) begin n_fail++; $display("FAIL busy_in_stop: got %b want 1", cap_busy[FRAME_A-1]); end
        n_checks++; if (cap_busy[FRAME_A] !== 1'b0) begin n_fail++; $display("FAIL busy_after_idle: got %b want 0", cap_busy[FRAME_A]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [3];
        logic [4:0] cnt_after [3];
        int bad;
        v[0] = 8'h41; v[1] = 8'h42; v[2] = 8'h43;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    a_data = v[i]; a_valid = 1'b1;
                    @(negedge clk);
                    cnt_after[i] = a_count;
                end
                a_valid = 1'b0;
            end
            begin
                @(posedge clk); @(posedge clk);
                capture(0, 3 * FRAME_A + 1);
            end
        join
        n_checks++; if (cnt_after[0] !== 5'd1) begin n_fail++; $display("FAIL b2b_count_push1: got %0d want 1", cnt_after[0]); end
        n_checks++; if (cnt_after[1] !== 5'd1) begin n_fail++; $display("FAIL b2b_count_push_pop: got %0d want 1", cnt_after[1]); end
        n_checks++; if (cnt_after[2] !== 5'd2) begin n_fail++; $display("FAIL b2b_count_push3: got %0d want 2", cnt_after[2]); end
        for (int f = 0; f < 3; f++) begin
            bad = 0;
            for (int k = 0; k < FRAME_A; k++) if (cap_line[f*FRAME_A+k] !== exp_level(v[f], 8, 0, k)) bad++;
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_frame%0d: %0d wrong bit-times, want 0", f, bad); end
        end
        n_checks++; if (cap_cnt[FRAME_A-1] !== 5'd2) begin n_fail++; $display("FAIL b2b_count_before_pop2: got %0d want 2", cap_cnt[FRAME_A-1]); end
        n_checks++; if (cap_cnt[FRAME_A] !== 5'd1) begin n_fail++; $display("FAIL b2b_count_after_pop2: got %0d want 1", cap_cnt[FRAME_A]); end
        n_checks++; if (cap_cnt[2*FRAME_A] !== 5'd0) begin n_fail++; $display("FAIL b2b_count_after_pop3: got %0d want 0", cap_cnt[2*FRAME_A]); end
        n_checks++; if (cap_busy[3*FRAME_A] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", cap_busy[3*FRAME_A]); end
    endtask

    task automatic test_overflow();
        logic [4:0] cnt [18];
        logic       rdy [18];
        int bad;
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    a_data = 8'(8'h60 + i); a_valid = 1'b1;
                    @(negedge clk);
                    cnt[i] = a_count; rdy[i] = a_ready;
                end
                a_valid = 1'b0;
            end
            begin
                @(posedge clk); @(posedge clk);
                capture(0, 17 * FRAME_A + 1);
            end
        join
        n_checks++; if (rdy[15] !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_at15: got %b want 1", rdy[15]); end
        n_checks++; if (cnt[16] !== 5'd16) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 16", cnt[16]); end
        n_checks++; if (rdy[16] !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full: got %b want 0", rdy[16]); end
        n_checks++; if (cnt[17] !== 5'd16) begin n_fail++; $display("FAIL ovf_count_after_drop: got %0d want 16", cnt[17]); end
        for (int f = 0; f < 17; f++) begin
            bad = 0;
            for (int k = 0; k < FRAME_A; k++) if (cap_line[f*FRAME_A+k] !== exp_level(8'(8'h60 + f), 8, 0, k)) bad++;
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ovf_frame%0d: %0d wrong bit-times, want 0", f, bad); end
        end
        n_checks++; if (cap_busy[17*FRAME_A] !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_end: got %b want 0", cap_busy[17*FRAME_A]); end
    endtask

    task automatic test_short_frame();
        logic [7:0] v [2];
        int bad;
        v[0] = 8'hFF; v[1] = 8'hE0;
        for (int f = 0; f < 2; f++) begin
            bad = 0;
            b_data = v[f]; b_valid = 1'b1;
            @(posedge clk); #1 b_valid = 1'b0;
            @(negedge clk);
            capture(1, FRAME_B + 1);
            for (int k = 0; k < FRAME_B; k++) if (cap_line[k] !== exp_level(v[f], 5, 0, k)) bad++;
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL short_frame_%0d: %0d wrong bit-times, want 0", f, bad); end
            n_checks++; if (cap_busy[FRAME_B-11] !== 1'b1) begin n_fail++; $display("FAIL short_stop2_busy_%0d: got %b want 1", f, cap_busy[FRAME_B-11]); end
            n_checks++; if (cap_busy[FRAME_B] !== 1'b0) begin n_fail++; $display("FAIL short_busy_end_%0d: got %b want 0", f, cap_busy[FRAME_B]); end
        end
        n_checks++; if (cap_line[10] !== 1'b0) begin n_fail++; $display("FAIL short_upper_bits_ignored: got %b want 0", cap_line[10]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        a_data = 8'h07; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        capture(0, FRAME_A + 1);
        n_checks++; if (cap_line[95] !== 1'b1) begin n_fail++; $display("FAIL parity_even: got %b want 1", cap_line[95]); end
        n_checks++; if (cap_busy[109] !== 1'b1 || cap_busy[110] !== 1'b0) begin n_fail++; $display("FAIL parity_even_len: got %b%b want 10", cap_busy[109], cap_busy[110]); end
        c_data = 8'h07; c_valid = 1'b1;
        @(posedge clk); #1 c_valid = 1'b0;
        @(negedge clk);
        capture(2, FRAME_A + 1);
        n_checks++; if (cap_line[95] !== 1'b0) begin n_fail++; $display("FAIL parity_odd: got %b want 0", cap_line[95]); end
        n_checks++; if (cap_line[105] !== 1'b1 || cap_busy[110] !== 1'b0) begin n_fail++; $display("FAIL parity_odd_stop: got %b%b want 10", cap_line[105], cap_busy[110]); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [7:0] v [4];
        int bad;
        v[0] = 8'hF0; v[1] = 8'h11; v[2] = 8'h22; v[3] = 8'h33;
        for (int i = 0; i < 4; i++) begin
            a_data = v[i]; a_valid = 1'b1;
            @(negedge clk);
        end
        a_valid = 1'b0;
        repeat (42) @(negedge clk);
        n_checks++; if (a_line !== 1'b0) begin n_fail++; $display("FAIL rstmid_data_bit3: got %b want 0", a_line); end
        n_checks++; if (a_count !== 5'd3) begin n_fail++; $display("FAIL rstmid_queued: got %0d want 3", a_count); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (a_line !== 1'b1) begin n_fail++; $display("FAIL rstmid_line: got %b want 1", a_line); end
        n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", a_count); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
        rst = 1'b0;
        capture(0, 300);
        bad = 0;
        for (int k = 0; k < 300; k++) if (cap_line[k] !== 1'b1 || cap_busy[k] !== 1'b0) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d active cycles, want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_short_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
